pq_cmd_client: RTL and testbench

Client-side bridge that drives a hardware priority queue through the pq_if client modport (kvi/enq/deq out; full/busy/empty/kvo in). Accepts single commands (ENQ, DEQ, FLUSH) over a valid/ready command port and obeys the device's busy/full/empty rules. Returns one or more responses over a valid/ready response port. Sits between testbench or system logic and any HWPQ implementation; one instance per queue.

---
 rtl/pq_pkg.sv | 21 ++
 rtl/pq_cmd_client.sv | 235 +++++++++++++++++++++++
 tb/tb_pq_cmd_client.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pq_pkg.sv
// pq_pkg: shared key/value type and command/response encodings for the priority-queue client.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package pq_pkg;

  typedef struct packed {
    logic [15:0] key;
    logic [15:0] val;
  } kv_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_ENQ   = 2'b01;
  localparam logic [1:0] OP_DEQ   = 2'b10;
  localparam logic [1:0] OP_FLUSH = 2'b11;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_FULL    = 2'b01;
  localparam logic [1:0] ERR_EMPTY   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/pq_cmd_client.sv
// pq_cmd_client: bridges a valid/ready command port onto a hardware priority queue client port.
// Latency: NOP responds 1 cycle after accept, ENQ/DEQ 2 cycles; FLUSH streams one response per item.
// Backpressure: cmd_ready only in IDLE; rsp_* held until rsp_ready; device busy bounded by BUSY_TIMEOUT.
// Optional: define PQ_ORDER_CHECK_EN to add the sticky order_err output (FLUSH key ordering check).
module pq_cmd_client
  import pq_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  kv_t              cmd_kv,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output kv_t              rsp_kv,
  output logic [1:0]       rsp_err,
  output logic             rsp_last,
  output kv_t              pq_kvi,
  output logic             pq_enq,
  output logic             pq_deq,
  input  logic             pq_full,
  input  logic             pq_busy,
  input  logic             pq_empty,
  input  kv_t              pq_kvo,
  output logic [CNT_W-1:0] enq_cnt,
  output logic [CNT_W-1:0] deq_cnt
`ifdef PQ_ORDER_CHECK_EN
  ,
  output logic             order_err
`endif
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  kv_t           kv_q, kv_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          have_q, have_d;       // popped FLUSH item captured but not yet presented
  logic          rsp_valid_d, rsp_last_d;
  kv_t           rsp_kv_d;
  logic [1:0]    rsp_err_d;
  logic          enq_c, deq_c;
  logic          fin;                  // finish command with a single last=1 response
  logic [1:0]    fin_err;
  kv_t           fin_kv;

  assign cmd_ready = (state_q == S_IDLE) & ~rst;
  assign pq_enq    = enq_c & ~rst;
  assign pq_deq    = deq_c & ~rst;
  assign pq_kvi    = kv_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, device pulses and next values of the response/datapath registers.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    kv_d        = kv_q;
    tmo_d       = tmo_q;
    have_d      = have_q;
    rsp_valid_d = rsp_valid;
    rsp_kv_d    = rsp_kv;
    rsp_err_d   = rsp_err;
    rsp_last_d  = rsp_last;
    enq_c       = 1'b0;
    deq_c       = 1'b0;
    fin         = 1'b0;
    fin_err     = ERR_OK;
    fin_kv      = '0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d = cmd_op;
          kv_d = cmd_kv;
          if (cmd_op == OP_NOP) fin = 1'b1;
          else                  state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (pq_busy) begin
          if (tmo_q == TMO_LAST) begin
            fin     = 1'b1;
            fin_err = ERR_TIMEOUT;
            fin_kv  = (op_q == OP_ENQ) ? kv_q : '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end else begin
          case (op_q)
            OP_ENQ: begin
              fin    = 1'b1;
              fin_kv = kv_q;
              if (pq_full) fin_err = ERR_FULL;
              else         enq_c   = 1'b1;
            end
            OP_DEQ: begin
              fin = 1'b1;
              if (pq_empty) begin
                fin_err = ERR_EMPTY;
              end else begin
                deq_c  = 1'b1;
                fin_kv = pq_kvo;
              end
            end
            OP_FLUSH: begin
              if (pq_empty) begin
                fin     = 1'b1;
                fin_err = ERR_EMPTY;
              end else begin
                state_d = S_DRAIN;
                have_d  = 1'b0;
              end
            end
            default: fin = 1'b1;
          endcase
        end
      end
      S_DRAIN: begin
        if (rsp_valid) begin
          // A non-final item is out; device access waits for its handshake.
          if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            have_d      = 1'b0;
            tmo_d       = '0;
          end
        end else if (pq_busy) begin
          if (tmo_q == TMO_LAST) begin
            fin     = 1'b1;
            fin_err = ERR_TIMEOUT;
            fin_kv  = have_q ? rsp_kv : '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end else if (have_q) begin
          // Device has settled after the pop: empty now means this item is the last one.
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_OK;
          rsp_last_d  = pq_empty;
          if (pq_empty) state_d = S_RESP;
        end else if (!pq_empty) begin
          deq_c    = 1'b1;
          rsp_kv_d = pq_kvo;
          have_d   = 1'b1;
          tmo_d    = '0;
        end else begin
          fin     = 1'b1;
          fin_err = ERR_EMPTY;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      state_d     = S_RESP;
      rsp_valid_d = 1'b1;
      rsp_err_d   = fin_err;
      rsp_kv_d    = fin_kv;
      rsp_last_d  = 1'b1;
    end
    if (state_d != state_q) tmo_d = '0;
  end

  // Datapath and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= OP_NOP;
      kv_q      <= '0;
      tmo_q     <= '0;
      have_q    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_kv    <= '0;
      rsp_err   <= ERR_OK;
      rsp_last  <= 1'b0;
    end else begin
      op_q      <= op_d;
      kv_q      <= kv_d;
      tmo_q     <= tmo_d;
      have_q    <= have_d;
      rsp_valid <= rsp_valid_d;
      rsp_kv    <= rsp_kv_d;
      rsp_err   <= rsp_err_d;
      rsp_last  <= rsp_last_d;
    end
  end

  // Saturating pulse counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      enq_cnt <= '0;
      deq_cnt <= '0;
    end else begin
      if (pq_enq && enq_cnt != '1) enq_cnt <= enq_cnt + 1'b1;
      if (pq_deq && deq_cnt != '1) deq_cnt <= deq_cnt + 1'b1;
    end
  end

`ifdef PQ_ORDER_CHECK_EN
  logic [15:0] prev_key;
  logic        prev_vld;

  // Popped keys within one FLUSH must be non-decreasing; history restarts at FLUSH start.
  always_ff @(posedge clk) begin
    if (rst) begin
      order_err <= 1'b0;
      prev_key  <= '0;
      prev_vld  <= 1'b0;
    end else if (state_q == S_ISSUE && state_d == S_DRAIN) begin
      prev_vld <= 1'b0;
    end else if (pq_deq && state_q == S_DRAIN) begin
      if (prev_vld && pq_kvo.key < prev_key) order_err <= 1'b1;
      prev_key <= pq_kvo.key;
      prev_vld <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pq_cmd_client.sv
module tb_pq_cmd_client;
  import pq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  kv_t         cmd_kv;
  logic        rsp_valid, rsp_ready, rsp_last;
  kv_t         rsp_kv;
  logic [1:0]  rsp_err;
  kv_t         pq_kvi, pq_kvo;
  logic        pq_enq, pq_deq, pq_full, pq_busy, pq_empty;
  logic [15:0] enq_cnt, deq_cnt;
`ifdef PQ_ORDER_CHECK_EN
  logic        order_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pq_cmd_client #(.BUSY_TIMEOUT(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_kv(cmd_kv),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_kv(rsp_kv),
    .rsp_err(rsp_err), .rsp_last(rsp_last),
    .pq_kvi(pq_kvi), .pq_enq(pq_enq), .pq_deq(pq_deq),
    .pq_full(pq_full), .pq_busy(pq_busy), .pq_empty(pq_empty), .pq_kvo(pq_kvo),
    .enq_cnt(enq_cnt), .deq_cnt(deq_cnt)
`ifdef PQ_ORDER_CHECK_EN
    , .order_err(order_err)
`endif
  );

  // Behavioural priority queue: sorted by key, head at mem[0].
  logic busy_force, full_force, tb_clr;
  kv_t  mem [8];
  int   dev_cnt = 0;

  assign pq_kvo   = mem[0];
  assign pq_empty = (dev_cnt == 0);
  assign pq_full  = full_force | (dev_cnt == 8);
  assign pq_busy  = busy_force;

  always @(posedge clk) begin
    kv_t nm [8];
    int  nc;
    int  p;
    nm = mem;
    nc = dev_cnt;
    if (tb_clr) begin
      for (int j = 0; j < 8; j++) nm[j] = '0;
      nc = 0;
    end else begin
      if (pq_deq && nc > 0) begin
        for (int j = 0; j < 7; j++) nm[j] = nm[j+1];
        nm[7] = '0;
        nc--;
      end
      if (pq_enq && nc < 8) begin
        p = nc;
        for (int j = 7; j >= 0; j--) if (j < nc && nm[j].key > pq_kvi.key) p = j;
        for (int j = 7; j > 0; j--) if (j > p) nm[j] = nm[j-1];
        nm[p] = pq_kvi;
        nc++;
      end
    end
    mem     <= nm;
    dev_cnt <= nc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE and wait for the first response; counts device pulses on the way.
  int n_enq, n_deq, wait_k;
  task automatic run_cmd(input logic [1:0] op, input logic [15:0] key);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_kv    = '{key: key, val: ~key};
    n_enq = 0;
    n_deq = 0;
    tick();
    cmd_valid = 1'b0;
    wait_k = 0;
    while (!rsp_valid && wait_k < 200) begin
      n_enq += int'(pq_enq);
      n_deq += int'(pq_deq);
      tick();
      wait_k++;
    end
    if (wait_k >= 200) chk("rsp_wait_bound", 32'(wait_k), 32'd0);
  endtask

  logic [15:0] fkeys [8];
  logic        flasts [8];
  int          nr;
  kv_t         snap_kv;
  logic        stable_ok, ready_low;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_kv = '0; rsp_ready = 1'b1;
    busy_force = 1'b0; full_force = 1'b0; tb_clr = 1'b1;
    tick(); tick();

    // Reset state.
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_rsp_kv",    rsp_kv,         32'd0);
    chk("rst_pq_kvi",    pq_kvi,         32'd0);
    chk("rst_pulses",    {30'd0, pq_enq, pq_deq}, 32'd0);
    chk("rst_cnts",      {enq_cnt, deq_cnt}, 32'd0);
    rst = 1'b0; tb_clr = 1'b0;
    tick();
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // ENQ key 5: check the device pulse in the ISSUE cycle.
    cmd_valid = 1'b1; cmd_op = OP_ENQ; cmd_kv = '{key: 16'd5, val: 16'h0055};
    tick();
    cmd_valid = 1'b0;
    chk("enq5_pulse", 32'(pq_enq), 32'd1);
    chk("enq5_kvi",   32'(pq_kvi.key), 32'd5);
    chk("enq5_nodeq", 32'(pq_deq), 32'd0);
    tick();
    chk("enq5_pulse_end", 32'(pq_enq), 32'd0);
    chk("enq5_valid", 32'(rsp_valid), 32'd1);
    chk("enq5_err",   32'(rsp_err), 32'd0);
    chk("enq5_kv",    rsp_kv, 32'h0005_0055);
    chk("enq5_last",  32'(rsp_last), 32'd1);
    chk("enq5_cnt",   32'(enq_cnt), 32'd1);
    tick();
    chk("enq5_done", 32'(rsp_valid), 32'd0);

    // NOP: OK response, no device access.
    run_cmd(OP_NOP, 16'd77);
    chk("nop_err",    32'(rsp_err), 32'd0);
    chk("nop_last",   32'(rsp_last), 32'd1);
    chk("nop_kv",     rsp_kv, 32'd0);
    chk("nop_pulses", 32'(n_enq + n_deq), 32'd0);
    tick();

    // DEQ the 5, then DEQ on the now-empty queue.
    run_cmd(OP_DEQ, 16'd0);
    chk("deq5_pulses", 32'(n_deq), 32'd1);
    chk("deq5_err",    32'(rsp_err), 32'd0);
    chk("deq5_key",    32'(rsp_kv.key), 32'd5);
    chk("deq5_cnt",    32'(deq_cnt), 32'd1);
    tick();
    run_cmd(OP_DEQ, 16'd0);
    chk("deq_empty_pulses", 32'(n_deq), 32'd0);
    chk("deq_empty_err",    32'(rsp_err), 32'd2);
    chk("deq_empty_last",   32'(rsp_last), 32'd1);
    chk("deq_empty_cnt",    32'(deq_cnt), 32'd1);
    tick();

    // ENQ 9,3,7 then FLUSH: keys come out 3,7,9 with last only on 9.
    run_cmd(OP_ENQ, 16'd9); tick();
    run_cmd(OP_ENQ, 16'd3); tick();
    run_cmd(OP_ENQ, 16'd7); tick();
    chk("three_enq_cnt", 32'(enq_cnt), 32'd4);
    cmd_valid = 1'b1; cmd_op = OP_FLUSH; cmd_kv = '0;
    tick();
    cmd_valid = 1'b0;
    n_deq = 0; nr = 0; wait_k = 0;
    while (wait_k < 300) begin
      n_deq += int'(pq_deq);
      if (rsp_valid && nr < 8) begin
        fkeys[nr]  = rsp_kv.key;
        flasts[nr] = rsp_last;
        nr++;
        if (rsp_last) break;
      end
      tick();
      wait_k++;
    end
    chk("flush_nrsp",  32'(nr), 32'd3);
    chk("flush_key0",  32'(fkeys[0]), 32'd3);
    chk("flush_key1",  32'(fkeys[1]), 32'd7);
    chk("flush_key2",  32'(fkeys[2]), 32'd9);
    chk("flush_lasts", {29'd0, flasts[0], flasts[1], flasts[2]}, 32'b001);
    chk("flush_pulses", 32'(n_deq), 32'd3);
    chk("flush_cnt",   32'(deq_cnt), 32'd4);
`ifdef PQ_ORDER_CHECK_EN
    chk("flush_order_err", 32'(order_err), 32'd0);
`endif
    tick();

    // FLUSH of an empty queue.
    run_cmd(OP_FLUSH, 16'd0);
    chk("flush_empty_err",  32'(rsp_err), 32'd2);
    chk("flush_empty_last", 32'(rsp_last), 32'd1);
    tick();

    // Busy held through an ENQ: TIMEOUT after 64 busy cycles, no pulse.
    busy_force = 1'b1;
    run_cmd(OP_ENQ, 16'd1);
    chk("tmo_cycles", 32'(wait_k), 32'd64);
    chk("tmo_err",    32'(rsp_err), 32'd3);
    chk("tmo_last",   32'(rsp_last), 32'd1);
    chk("tmo_pulses", 32'(n_enq), 32'd0);
    chk("tmo_cnt",    32'(enq_cnt), 32'd4);
    repeat (6) tick();
    busy_force = 1'b0;

    // ENQ into a full device with the response held back for 10 cycles.
    full_force = 1'b1; rsp_ready = 1'b0;
    run_cmd(OP_ENQ, 16'h22);
    chk("full_err",    32'(rsp_err), 32'd1);
    chk("full_last",   32'(rsp_last), 32'd1);
    chk("full_pulses", 32'(n_enq), 32'd0);
    snap_kv = rsp_kv; stable_ok = 1'b1; ready_low = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!rsp_valid || rsp_err != 2'd1 || !rsp_last || rsp_kv != snap_kv) stable_ok = 1'b0;
      if (cmd_ready) ready_low = 1'b0;
    end
    chk("hold_stable",    32'(stable_ok), 32'd1);
    chk("hold_cmd_ready", 32'(ready_low), 32'd1);
    chk("full_cnt",       32'(enq_cnt), 32'd4);
    rsp_ready = 1'b1; full_force = 1'b0;
    tick();
    chk("hold_released", 32'(rsp_valid), 32'd0);
    chk("hold_idle",     32'(cmd_ready), 32'd1);

    // Reset in the middle of a FLUSH with a response pending.
    run_cmd(OP_ENQ, 16'd4); tick();
    run_cmd(OP_ENQ, 16'd2); tick();
    rsp_ready = 1'b0;
    run_cmd(OP_FLUSH, 16'd0);
    chk("drain_first_key",  32'(rsp_kv.key), 32'd2);
    chk("drain_first_last", 32'(rsp_last), 32'd0);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_deq",   32'(pq_deq), 32'd0);
    chk("mid_rst_cnts",  {enq_cnt, deq_cnt}, 32'd0);
    rst = 1'b0; rsp_ready = 1'b1; tb_clr = 1'b1;
    tick();
    tb_clr = 1'b0;
    chk("mid_rst_idle",  32'(cmd_ready), 32'd1);
    chk("mid_rst_quiet", 32'(rsp_valid), 32'd0);
`ifdef PQ_ORDER_CHECK_EN
    chk("mid_rst_order_err", 32'(order_err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
